// File: rtl/commit_trace_tx.sv
// commit_trace_tx -- commit trace transmitter.
//
// Collects up to six commit events per cycle from two retire pipes (store,
// register write and hilo write per pipe). Present events are packed into
// consecutive slots of a trace FIFO in one cycle. The FIFO head is offered
// to a valid/ready consumer.
//
// A cycle's events are kept together. When they do not all fit, the whole
// cycle is dropped, and the drop is recorded in overflow and drop_cnt.
//
// Optional feature macro: COMMIT_TRACE_HILO_EN
//   defined   -> hilo writes are traced as kind 1
//   undefined -> hilo inputs are ignored and never counted
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   reg_we_*/reg_waddr_*/reg_wdata_* register write commit, pipes A/B
//   hilo_we_*/hilo_*                 hilo write commit {hi,lo}
//   st_we_*/st_addr_*/st_data_*      store commit
//   trace_valid/trace_ready          head handshake
//   trace_kind/addr/data             head entry (0=reg, 1=hilo, 2=store)
//   overflow                         sticky, some cycle was dropped
//   drop_cnt                         dropped cycles, saturating

package commit_trace_pkg;
    typedef enum logic [1:0] {
        K_REG   = 2'd0,
        K_HILO  = 2'd1,
        K_STORE = 2'd2
    } kind_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [63:0] data;
    } trace_ent_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        hilo_we;
        logic [63:0] hilo;
        logic        st_we;
        logic [15:0] st_addr;
        logic [31:0] st_data;
    } commit_req_t;
endpackage

// Per-pipe event formatter: slot 0 = store, 1 = reg, 2 = hilo.
module commit_trace_lane
    import commit_trace_pkg::*;
(
    input  commit_req_t       req,
    output logic [2:0]        ev_vld,
    output trace_ent_t [2:0]  ev
);
    always_comb begin
        ev[0].kind = K_STORE;
        ev[0].addr = req.st_addr;
        ev[0].data = {32'd0, req.st_data};
        ev[1].kind = K_REG;
        ev[1].addr = {11'd0, req.reg_waddr};
        ev[1].data = {32'd0, req.reg_wdata};
        ev[2].kind = K_HILO;
        ev[2].addr = 16'd0;
        ev[2].data = req.hilo;
    end

    assign ev_vld[0] = req.st_we;
    // Writes to r0 are architecturally void and are not traced.
    assign ev_vld[1] = req.reg_we && (req.reg_waddr != 5'd0);

`ifdef COMMIT_TRACE_HILO_EN
    assign ev_vld[2] = req.hilo_we;
`else
    logic unused_hilo;
    assign unused_hilo = ^{req.hilo_we, req.hilo};
    assign ev_vld[2]   = 1'b0;
`endif
endmodule

module commit_trace_tx
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we_a,
    input  logic [4:0]  reg_waddr_a,
    input  logic [31:0] reg_wdata_a,
    input  logic        reg_we_b,
    input  logic [4:0]  reg_waddr_b,
    input  logic [31:0] reg_wdata_b,
    input  logic        hilo_we_a,
    input  logic [63:0] hilo_a,
    input  logic        hilo_we_b,
    input  logic [63:0] hilo_b,
    input  logic        st_we_a,
    input  logic [15:0] st_addr_a,
    input  logic [31:0] st_data_a,
    input  logic        st_we_b,
    input  logic [15:0] st_addr_b,
    input  logic [31:0] st_data_b,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [1:0]  trace_kind,
    output logic [15:0] trace_addr,
    output logic [63:0] trace_data,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    localparam int NUM_LANES = 2;
    localparam int NUM_EV    = 3 * NUM_LANES;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;

    commit_req_t [NUM_LANES-1:0]       req;
    logic        [NUM_LANES-1:0][2:0]  lane_vld;
    trace_ent_t  [NUM_LANES-1:0][2:0]  lane_ev;
    logic        [NUM_EV-1:0]          ev_vld;
    trace_ent_t  [NUM_EV-1:0]          ev;

    assign req[0] = '{reg_we: reg_we_a, reg_waddr: reg_waddr_a, reg_wdata: reg_wdata_a,
                      hilo_we: hilo_we_a, hilo: hilo_a,
                      st_we: st_we_a, st_addr: st_addr_a, st_data: st_data_a};
    assign req[1] = '{reg_we: reg_we_b, reg_waddr: reg_waddr_b, reg_wdata: reg_wdata_b,
                      hilo_we: hilo_we_b, hilo: hilo_b,
                      st_we: st_we_b, st_addr: st_addr_b, st_data: st_data_b};

    // Lane-major flattening gives the enqueue order
    // store A, reg A, hilo A, store B, reg B, hilo B.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        commit_trace_lane u_lane (
            .req    (req[l]),
            .ev_vld (lane_vld[l]),
            .ev     (lane_ev[l])
        );
        for (genvar s = 0; s < 3; s++) begin : g_slot
            assign ev_vld[3*l+s] = lane_vld[l][s];
            assign ev[3*l+s]     = lane_ev[l][s];
        end
    end

    // Each present event goes to slot wr_ptr + (number of present events
    // before it). This packs the events without gaps.
    logic [2:0] off [NUM_EV];
    logic [2:0] n_ev;

    always_comb begin
        n_ev = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            off[i] = n_ev;
            n_ev   = n_ev + {2'd0, ev_vld[i]};
        end
    end

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          pop, accept, drop;
    trace_ent_t    mem [DEPTH];
    trace_ent_t    head;

    assign trace_valid = (count != '0);
    assign pop         = trace_valid && trace_ready;
    // The space this cycle's pop releases counts toward this cycle's push.
    assign free        = CW'(DEPTH) - count + {{AW{1'b0}}, pop};
    assign accept      = (n_ev != 3'd0) && (CW'(n_ev) <= free);
    assign drop        = (n_ev != 3'd0) && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + AW'(n_ev);
            count <= count + (accept ? CW'(n_ev) : CW'(0)) - {{AW{1'b0}}, pop};
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // The storage array is not reset. Only occupied slots are visible,
    // because the outputs are gated by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (ev_vld[i])
                    mem[wr_ptr + AW'(off[i])] <= ev[i];
            end
        end
    end

    // The head fields come only from stored state. They stay stable until a pop.
    assign head       = mem[rd_ptr];
    assign trace_kind = trace_valid ? head.kind : 2'd0;
    assign trace_addr = trace_valid ? head.addr : 16'd0;
    assign trace_data = trace_valid ? head.data : 64'd0;
endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_we_a, reg_we_b;
    logic [4:0]  reg_waddr_a, reg_waddr_b;
    logic [31:0] reg_wdata_a, reg_wdata_b;
    logic        hilo_we_a, hilo_we_b;
    logic [63:0] hilo_a, hilo_b;
    logic        st_we_a, st_we_b;
    logic [15:0] st_addr_a, st_addr_b;
    logic [31:0] st_data_a, st_data_b;
    logic        trace_valid, trace_ready;
    logic [1:0]  trace_kind;
    logic [15:0] trace_addr;
    logic [63:0] trace_data;
    logic        overflow;
    logic [15:0] drop_cnt;

    commit_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_we_a(reg_we_a), .reg_waddr_a(reg_waddr_a), .reg_wdata_a(reg_wdata_a),
        .reg_we_b(reg_we_b), .reg_waddr_b(reg_waddr_b), .reg_wdata_b(reg_wdata_b),
        .hilo_we_a(hilo_we_a), .hilo_a(hilo_a),
        .hilo_we_b(hilo_we_b), .hilo_b(hilo_b),
        .st_we_a(st_we_a), .st_addr_a(st_addr_a), .st_data_a(st_data_a),
        .st_we_b(st_we_b), .st_addr_b(st_addr_b), .st_data_b(st_data_b),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_addr(trace_addr), .trace_data(trace_data),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_drop;
    int   total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        reg_we_a = 0; reg_waddr_a = 0; reg_wdata_a = 0;
        reg_we_b = 0; reg_waddr_b = 0; reg_wdata_b = 0;
        hilo_we_a = 0; hilo_a = 0; hilo_we_b = 0; hilo_b = 0;
        st_we_a = 0; st_addr_a = 0; st_data_a = 0;
        st_we_b = 0; st_addr_b = 0; st_data_b = 0;
    endtask

    // Checks the current head against the model. Then it applies one clock
    // edge of the spec rules to the model and to the DUT.
    task automatic tick();
        ent_t ev[$];
        int   free;
        bit   pop;
        chk("valid", trace_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("kind", trace_kind, q[0].k);
            chk("addr", trace_addr, q[0].a);
            chk("data", trace_data, q[0].d);
        end
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);

        if (st_we_a) ev.push_back('{2'd2, st_addr_a, {32'd0, st_data_a}});
        if (reg_we_a && reg_waddr_a != 0) ev.push_back('{2'd0, {11'd0, reg_waddr_a}, {32'd0, reg_wdata_a}});
`ifdef COMMIT_TRACE_HILO_EN
        if (hilo_we_a) ev.push_back('{2'd1, 16'd0, hilo_a});
`endif
        if (st_we_b) ev.push_back('{2'd2, st_addr_b, {32'd0, st_data_b}});
        if (reg_we_b && reg_waddr_b != 0) ev.push_back('{2'd0, {11'd0, reg_waddr_b}, {32'd0, reg_wdata_b}});
`ifdef COMMIT_TRACE_HILO_EN
        if (hilo_we_b) ev.push_back('{2'd1, 16'd0, hilo_b});
`endif
        pop  = (q.size() != 0) && trace_ready;
        free = DEPTH - q.size() + int'(pop);
        if (pop) void'(q.pop_front());
        if (ev.size() <= free) begin
            foreach (ev[i]) q.push_back(ev[i]);
        end else begin
            m_ovf = 1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
        @(negedge clk);
    endtask

    task automatic chk_idle_reset();
        chk("rst_valid", trace_valid, 0);
        chk("rst_kind", trace_kind, 0);
        chk("rst_addr", trace_addr, 0);
        chk("rst_data", trace_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
    endtask

    initial begin
        total = 0; bad = 0; m_ovf = 0; m_drop = 0;
        rst_n = 0; trace_ready = 0; clr_in();
        repeat (2) @(negedge clk);
        chk_idle_reset();
        rst_n = 1;

        // Single register write event.
        trace_ready = 1;
        reg_we_a = 1; reg_waddr_a = 5'd3; reg_wdata_a = 32'h1234;
        tick(); clr_in();
        chk("single_kind", trace_kind, 0);
        chk("single_addr", trace_addr, 3);
        chk("single_data", trace_data, 64'h1234);
        tick();
        chk("single_gone", trace_valid, 0);

        // All six events arrive in one cycle.
        st_we_a = 1; st_addr_a = 16'h0A0A; st_data_a = 32'hA0000001;
        reg_we_a = 1; reg_waddr_a = 5'd7; reg_wdata_a = 32'hA0000002;
        hilo_we_a = 1; hilo_a = 64'hA0000003_A0000004;
        st_we_b = 1; st_addr_b = 16'h0B0B; st_data_b = 32'hB0000001;
        reg_we_b = 1; reg_waddr_b = 5'd31; reg_wdata_b = 32'hB0000002;
        hilo_we_b = 1; hilo_b = 64'hB0000003_B0000004;
        tick(); clr_in();
        chk("six_first_kind", trace_kind, 2);
        chk("six_first_addr", trace_addr, 16'h0A0A);
        repeat (7) tick();

        // A write to r0 produces no trace entry.
        reg_we_b = 1; reg_waddr_b = 0; reg_wdata_b = 32'hFFFF;
        tick(); clr_in();
        chk("r0_ignored", trace_valid, 0);
        tick();

        // Overflow: fill to 14, drop a 3-event cycle, then accept 2 more.
        trace_ready = 0;
        for (int i = 0; i < 7; i++) begin
            st_we_a = 1; st_addr_a = 16'(i); st_data_a = $urandom;
            st_we_b = 1; st_addr_b = 16'(i + 100); st_data_b = $urandom;
            tick();
        end
        clr_in();
        st_we_a = 1; reg_we_a = 1; reg_waddr_a = 5'd1; st_we_b = 1;
        tick(); clr_in();
        chk("ovf_set", overflow, 1);
        chk("ovf_drop1", drop_cnt, 1);
        st_we_a = 1; st_addr_a = 16'h1111; st_we_b = 1; st_addr_b = 16'h2222;
        tick(); clr_in();
        chk("ovf_drop_after_fit", drop_cnt, 1);
        st_we_a = 1;
        tick(); clr_in();
        chk("ovf_full_drop2", drop_cnt, 2);
        trace_ready = 1;
        repeat (17) tick();
        chk("drained", trace_valid, 0);

        // The head holds steady while the consumer is stalled.
        trace_ready = 0;
        st_we_a = 1; st_addr_a = 16'hBEEF; st_data_a = 32'hCAFE0001;
        tick(); clr_in();
        for (int i = 0; i < 5; i++) begin
            chk("hold_kind", trace_kind, 2);
            chk("hold_addr", trace_addr, 16'hBEEF);
            chk("hold_data", trace_data, 64'hCAFE0001);
            tick();
        end
        trace_ready = 1;
        tick();

        // Pointers wrap across 40 single events.
        for (int i = 0; i < 40; i++) begin
            reg_we_a = 1; reg_waddr_a = 5'($urandom_range(1, 31)); reg_wdata_a = $urandom;
            tick();
        end
        clr_in();
        repeat (3) tick();

        // A hilo write is traced only when the feature is built in.
        hilo_we_a = 1; hilo_a = 64'hDEADBEEF_00000001;
        tick(); clr_in();
`ifdef COMMIT_TRACE_HILO_EN
        chk("hilo_kind", trace_kind, 1);
        chk("hilo_addr", trace_addr, 0);
        chk("hilo_data", trace_data, 64'hDEADBEEF00000001);
`else
        chk("hilo_absent", trace_valid, 0);
`endif
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            trace_ready = ($urandom_range(0, 3) != 0);
            st_we_a = ($urandom_range(0, 2) == 0); st_addr_a = $urandom; st_data_a = $urandom;
            reg_we_a = $urandom; reg_waddr_a = $urandom; reg_wdata_a = $urandom;
            hilo_we_a = ($urandom_range(0, 2) == 0); hilo_a = {$urandom, $urandom};
            st_we_b = ($urandom_range(0, 2) == 0); st_addr_b = $urandom; st_data_b = $urandom;
            reg_we_b = $urandom; reg_waddr_b = $urandom; reg_wdata_b = $urandom;
            hilo_we_b = ($urandom_range(0, 2) == 0); hilo_b = {$urandom, $urandom};
            tick();
        end

        // Reset while traffic is in flight discards everything.
        clr_in(); trace_ready = 0;
        st_we_a = 1; st_we_b = 1;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        q.delete(); m_ovf = 0; m_drop = 0;
        chk_idle_reset();
        @(negedge clk);
        rst_n = 1; clr_in();
        tick();
        reg_we_b = 1; reg_waddr_b = 5'd9; reg_wdata_b = 32'h99;
        tick(); clr_in();
        trace_ready = 1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
